// File: rtl/modexp_pkg.sv
// rtl/modexp_pkg.sv - shared state encoding and constants for the modexp sequencer
package modexp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    SCAN,
    SQ_RST,
    SQ_GO,
    SQ_WAIT,
    ML_RST,
    ML_GO,
    ML_WAIT,
    FIN
  } state_t;

  localparam int ONE  = 1;
  localparam int ZERO = 0;

endpackage

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - left-to-right square-and-multiply sequencer driving an external modular multiplier
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int NLEN = 1024,
  parameter int TAG  = 2,
  parameter int ELEN = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NLEN-1:0]      base,
  input  logic [ELEN-1:0]      exp,
  input  logic [NLEN-1:0]      N,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [NLEN-1:0]      result,
  output logic                 mm_reset,
  output logic [NLEN+TAG:0]    mm_in1,
  output logic [NLEN+TAG:0]    mm_in2,
  output logic                 mm_in_ready,
  input  logic [NLEN+TAG:0]    mm_out,
  input  logic                 mm_out_ready
);

  localparam int MW = NLEN + TAG + 1;
  localparam int IW = (ELEN > 1) ? $clog2(ELEN) : 1;

  state_t          state, state_next;
  logic [NLEN-1:0] base_q, n_q, acc;
  logic [ELEN-1:0] exp_q;
  logic [IW-1:0]   idx;

  logic mm_pulse;
  logic in_bad, product_bad, exp_bit, idx_zero, mul_phase;

  assign in_bad      = !n_q[0] || (n_q == '0) || (base_q >= n_q);
  assign product_bad = mm_out[MW-1] || (mm_out >= {{(TAG+1){1'b0}}, n_q});
  assign exp_bit     = exp_q[idx];
  assign idx_zero    = (idx == '0);
  assign mul_phase   = (state == ML_RST) || (state == ML_GO) || (state == ML_WAIT);

  // acc only changes at capture, so operands stay put from RST through WAIT
  assign mm_in1   = {{(TAG+1){1'b0}}, acc};
  assign mm_in2   = {{(TAG+1){1'b0}}, mul_phase ? base_q : acc};
  assign mm_reset = reset | mm_pulse;

  always_comb begin
    state_next  = state;
    mm_pulse    = 1'b0;
    mm_in_ready = 1'b0;
    case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = (in_bad || exp_q == '0) ? FIN : SCAN;
      SCAN:    if (exp_bit) state_next = idx_zero ? FIN : SQ_RST;
      SQ_RST: begin
        mm_pulse   = 1'b1;
        state_next = SQ_GO;
      end
      SQ_GO: begin
        mm_in_ready = 1'b1;
        state_next  = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (mm_out_ready) begin
          if (product_bad)   state_next = FIN;
          else if (exp_bit)  state_next = ML_RST;
          else if (idx_zero) state_next = FIN;
          else               state_next = SQ_RST;
        end
      end
      ML_RST: begin
        mm_pulse   = 1'b1;
        state_next = ML_GO;
      end
      ML_GO: begin
        mm_in_ready = 1'b1;
        state_next  = ML_WAIT;
      end
      ML_WAIT: begin
        if (mm_out_ready) state_next = (product_bad || idx_zero) ? FIN : SQ_RST;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      acc    <= '0;
      idx    <= '0;
      base_q <= '0;
      exp_q  <= '0;
      n_q    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exp;
            n_q    <= N;
            busy   <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
          end
        end
        CHECK: begin
          idx <= IW'(ELEN - 1);
          // early exits park their answer in acc so FIN can publish uniformly
          if (in_bad) begin
            err <= 1'b1;
            acc <= NLEN'(ZERO);
          end else if (exp_q == '0) begin
            acc <= (n_q == NLEN'(ONE)) ? NLEN'(ZERO) : NLEN'(ONE);
          end
        end
        SCAN: begin
          if (exp_bit) acc <= base_q;
          if (!idx_zero) idx <= idx - 1'b1;
        end
        SQ_WAIT: begin
          if (mm_out_ready) begin
            if (product_bad) begin
              err <= 1'b1;
              acc <= NLEN'(ZERO);
            end else begin
              acc <= mm_out[NLEN-1:0];
              if (!exp_bit && !idx_zero) idx <= idx - 1'b1;
            end
          end
        end
        ML_WAIT: begin
          if (mm_out_ready) begin
            if (product_bad) begin
              err <= 1'b1;
              acc <= NLEN'(ZERO);
            end else begin
              acc <= mm_out[NLEN-1:0];
              if (!idx_zero) idx <= idx - 1'b1;
            end
          end
        end
        FIN: begin
          result <= acc;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - directed-vector bench for modexp_ctrl with a behavioural a*b mod N multiplier
module tb_modexp_ctrl;

  localparam int NLEN = 8;
  localparam int TAG  = 2;
  localparam int ELEN = 8;
  localparam int MW   = NLEN + TAG + 1;
  localparam int TMM  = 10;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [NLEN-1:0] base, N;
  logic [ELEN-1:0] exp;
  logic            busy, done, err;
  logic [NLEN-1:0] result;
  logic            mm_reset, mm_in_ready;
  logic [MW-1:0]   mm_in1, mm_in2;
  logic [MW-1:0]   mm_out = '0;
  logic            mm_out_ready = 1'b0;

  logic [MW-1:0] op1 = '0, op2 = '0;
  logic          bad_product = 1'b0;
  int            cnt = 0;
  int            pulses = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  modexp_ctrl #(.NLEN(NLEN), .TAG(TAG), .ELEN(ELEN)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exp(exp), .N(N),
    .busy(busy), .done(done), .err(err), .result(result),
    .mm_reset(mm_reset), .mm_in1(mm_in1), .mm_in2(mm_in2), .mm_in_ready(mm_in_ready),
    .mm_out(mm_out), .mm_out_ready(mm_out_ready)
  );

  // multiplier stand-in: product appears TMM edges after the strobe, level until mm_reset
  always @(posedge clk) begin
    if (mm_in_ready) pulses <= pulses + 1;
    if (mm_reset) begin
      mm_out_ready <= 1'b0;
      cnt          <= 0;
    end else if (mm_in_ready) begin
      cnt <= TMM;
      op1 <= mm_in1;
      op2 <= mm_in2;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mm_out_ready <= 1'b1;
        mm_out       <= bad_product ? MW'(11'h1FF) : MW'((int'(op1) * int'(op2)) % int'(N));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic run(input logic [7:0] b, input logic [7:0] e, input logic [7:0] n,
                     input bit poke, output int np);
    int p0;
    bit ok;
    @(negedge clk);
    base  = b;
    exp   = e;
    N     = n;
    start = 1'b1;
    p0    = pulses;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_accept", busy, 1);
    check("done_cleared", done, 0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (poke && i == 20) begin
        start = 1'b1;
        base  = 8'd5;
      end else begin
        start = 1'b0;
        base  = b;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_within_budget", ok, 1);
    check("busy_low_at_done", busy, 0);
    np = pulses - p0;
  endtask

  initial begin
    int np;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    base  = '0;
    exp   = '0;
    N     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_mm_reset", mm_reset, 1);
    check("rst_mm_in_ready", mm_in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_mm_reset", mm_reset, 0);

    run(8'd88, 8'd7, 8'd187, 1'b0, np);
    check("88^7_result", result, 11);
    check("88^7_err", err, 0);
    check("88^7_mults", np, 4);

    run(8'd11, 8'd23, 8'd187, 1'b1, np);
    check("11^23_result", result, 88);
    check("11^23_mults", np, 7);

    run(8'd88, 8'd0, 8'd187, 1'b0, np);
    check("exp0_result", result, 1);
    check("exp0_mults", np, 0);

    run(8'd0, 8'd0, 8'd1, 1'b0, np);
    check("n1_exp0_result", result, 0);
    check("n1_exp0_err", err, 0);

    run(8'd88, 8'd1, 8'd187, 1'b0, np);
    check("exp1_result", result, 88);
    check("exp1_mults", np, 0);

    run(8'd88, 8'h80, 8'd187, 1'b0, np);
    check("exp80_result", result, 154);
    check("exp80_mults", np, 7);

    run(8'd88, 8'd7, 8'd186, 1'b0, np);
    check("even_n_err", err, 1);
    check("even_n_result", result, 0);
    check("even_n_mults", np, 0);

    run(8'd200, 8'd7, 8'd187, 1'b0, np);
    check("big_base_err", err, 1);
    check("big_base_result", result, 0);

    bad_product = 1'b1;
    run(8'd88, 8'd7, 8'd187, 1'b0, np);
    bad_product = 1'b0;
    check("bad_product_err", err, 1);
    check("bad_product_result", result, 0);
    check("bad_product_mults", np, 1);

    // abort a run while the first squaring is outstanding
    @(negedge clk);
    base  = 8'd88;
    exp   = 8'd7;
    N     = 8'd187;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mm_in_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_strobe_seen", seen, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_result", result, 0);
    check("abort_mm_reset", mm_reset, 1);
    check("abort_mm_in_ready", mm_in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", busy, 0);

    run(8'd2, 8'd10, 8'd187, 1'b0, np);
    check("fresh_result", result, 89);
    check("fresh_err", err, 0);
    check("fresh_mults", np, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
